arbiter8_rr: RTL and testbench

ARBITER8_RR -- requirements
Module: arbiter8_rr

---
 rtl/arbiter8_rr_pkg.sv | 16 +
 rtl/rr_pick8.sv | 30 +++
 rtl/arbiter8_rr.sv | 84 ++++++++
 tb/tb_arbiter8_rr.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arbiter8_rr_pkg.sv
// Shared definitions for the 8-way arbiter: FSM encoding, default tenure limit
// and a one-hot helper.
package arbiter8_rr_pkg;

  typedef enum logic {
    StArb = 1'b0,
    StOwn = 1'b1
  } arb_state_e;

  localparam int unsigned DefaultMaxHold = 15;

  function automatic logic [7:0] onehot8(input logic [2:0] id);
    onehot8 = 8'b1 << id;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational winner selection: fixed priority (index 7 highest) or
// round-robin searching upward from last_id + 1 with wrap-around.
module rr_pick8 (
  input  logic [7:0] req,
  input  logic       mode,
  input  logic [2:0] last_id,
  output logic [2:0] winner,
  output logic       any_req
);

  logic [2:0] idx;

  always_comb begin
    winner  = '0;
    any_req = |req;
    idx     = '0;
    if (!mode) begin
      for (int i = 0; i < 8; i++) begin
        if (req[i]) winner = 3'(i);
      end
    end else begin
      // Walk offsets far-to-near so the nearest asserted requester wins last.
      for (int off = 8; off >= 1; off--) begin
        idx = last_id + 3'(off);
        if (req[idx]) winner = idx;
      end
    end
  end

endmodule

// File: rtl/arbiter8_rr.sv
// 8-requester arbiter with fixed-priority / round-robin selection, registered
// one-hot grant and a bounded tenure that forces release after MAX_HOLD cycles.
module arbiter8_rr
  import arbiter8_rr_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DefaultMaxHold
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       mode,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       idle,
  output logic       timeout
);

  localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

  arb_state_e state;
  logic [3:0] hold_cnt;
  logic [2:0] last_id;
  logic [2:0] winner;
  logic       any_req;

  rr_pick8 u_pick (
    .req     (req),
    .mode    (mode),
    .last_id (last_id),
    .winner  (winner),
    .any_req (any_req)
  );

  assign idle = (req == 8'h00) && !grant_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StArb;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      last_id     <= 3'd7;
    end else begin
      unique case (state)
        StArb: begin
          timeout <= 1'b0;
          if (any_req) begin
            grant       <= onehot8(winner);
            grant_id    <= winner;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            last_id     <= winner;
            state       <= StOwn;
          end else begin
            grant       <= '0;
            grant_valid <= 1'b0;
          end
        end
        StOwn: begin
          if (!req[grant_id]) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            state       <= StArb;
          end else if (hold_cnt == HoldLast) begin
            // Grantee still requesting at its limit: forced release.
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
            state       <= StArb;
          end else begin
            timeout  <= 1'b0;
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: state <= StArb;
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter8_rr.sv
// Directed self-checking bench for arbiter8_rr with a 4-cycle tenure limit.
module tb_arbiter8_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       mode;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       idle;
  logic       timeout;

  int n_chk  = 0;
  int n_pass = 0;

  arbiter8_rr #(
    .MAX_HOLD (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .mode        (mode),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .idle        (idle),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    mode = 1'b0;
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'h00);
    check("rst_id", 32'(grant_id), 32'd0);
    check("rst_valid", 32'(grant_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    rst = 1'b0;

    // Fixed priority: 7 beats 5
    req = 8'hA0;
    tick();
    check("fp_grant", 32'(grant), 32'h80);
    check("fp_id", 32'(grant_id), 32'd7);
    check("fp_valid", 32'(grant_valid), 32'd1);
    check("fp_idle", 32'(idle), 32'd0);
    req = 8'h00;
    tick();
    check("fp_rel_valid", 32'(grant_valid), 32'd0);
    check("fp_rel_timeout", 32'(timeout), 32'd0);

    // No requests for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      check("quiet_idle", 32'(idle), 32'd1);
      check("quiet_grant", 32'(grant), 32'h00);
    end

    // Round-robin sweep, each grantee holds 2 cycles
    do_reset();
    mode = 1'b1;
    req  = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      check("rr_id", 32'(grant_id), 32'(k % 8));
      check("rr_grant", 32'(grant), 32'(8'h01 << (k % 8)));
      tick();
      check("rr_hold", 32'(grant_valid), 32'd1);
      req = 8'hFF & ~(8'h01 << (k % 8));
      tick();
      check("rr_gap", 32'(grant_valid), 32'd0);
      req = 8'hFF;
    end
    req = 8'h00;
    tick();
    tick();

    // Timeout after exactly 4 cycles, one ARB cycle, then regrant of id 2
    do_reset();
    mode = 1'b0;
    req  = 8'h04;
    tick();
    check("to_id", 32'(grant_id), 32'd2);
    for (int c = 1; c < 4; c++) begin
      tick();
      check("to_valid", 32'(grant_valid), 32'd1);
      check("to_nopulse", 32'(timeout), 32'd0);
    end
    tick();
    check("to_rel_valid", 32'(grant_valid), 32'd0);
    check("to_pulse", 32'(timeout), 32'd1);
    tick();
    check("to_regrant", 32'(grant_valid), 32'd1);
    check("to_regrant_id", 32'(grant_id), 32'd2);
    check("to_pulse_end", 32'(timeout), 32'd0);
    req = 8'h00;
    tick();
    tick();

    // Round-robin: timed-out id 3 yields to id 5
    do_reset();
    mode = 1'b1;
    req  = 8'h28;
    tick();
    check("rry_first", 32'(grant_id), 32'd3);
    repeat (3) tick();
    tick();
    check("rry_timeout", 32'(timeout), 32'd1);
    tick();
    check("rry_next", 32'(grant_id), 32'd5);
    check("rry_next_grant", 32'(grant), 32'h20);
    req = 8'h00;
    tick();
    tick();

    // Asynchronous reset mid-tenure
    do_reset();
    mode = 1'b0;
    req  = 8'h40;
    tick();
    check("ar_id", 32'(grant_id), 32'd6);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("ar_grant", 32'(grant), 32'h00);
    check("ar_valid", 32'(grant_valid), 32'd0);
    check("ar_timeout", 32'(timeout), 32'd0);
    req = 8'h01;
    #1;
    rst = 1'b0;
    tick();
    check("ar_after_id", 32'(grant_id), 32'd0);
    check("ar_after_grant", 32'(grant), 32'h01);
    req = 8'h00;
    tick();
    tick();

    // Mode toggled during a tenure has no effect on it
    do_reset();
    mode = 1'b0;
    req  = 8'h82;
    tick();
    check("mt_id", 32'(grant_id), 32'd7);
    mode = 1'b1;
    tick();
    check("mt_hold_id", 32'(grant_id), 32'd7);
    check("mt_hold_valid", 32'(grant_valid), 32'd1);
    tick();
    check("mt_hold2", 32'(grant), 32'h80);
    req = 8'h00;
    tick();
    check("mt_rel", 32'(grant_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
